// File: rtl/wt_fir_ctrl_pkg.sv
// Shared types and width helpers for the wavelet-core FIR sequencer.
package wt_fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    CAPT = 2'd3
  } state_t;

  function automatic int unsigned f_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

  // Compute-window counter width; never narrower than one bit.
  function automatic int unsigned f_cnt_w(input int unsigned calc);
    return (f_clog2(calc) < 1) ? 1 : f_clog2(calc);
  endfunction

  // FIFO pointer width; never narrower than one bit.
  function automatic int unsigned f_ptr_w(input int unsigned depth);
    return (f_clog2(depth) < 1) ? 1 : f_clog2(depth);
  endfunction

endpackage

// File: rtl/wt_fir_ctrl_fifo.sv
// Small synchronous result FIFO with registered count and no write-to-read bypass.
module wt_fir_ctrl_fifo
  import wt_fir_ctrl_pkg::*;
#(
  parameter int pDATA_W = 24,
  parameter int pDEPTH  = 2,
  localparam int CNT_W  = f_clog2(pDEPTH + 1)
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               isclr,
  input  logic               ipush,
  input  logic [pDATA_W-1:0] idat,
  input  logic               ipop,
  output logic [pDATA_W-1:0] odat,
  output logic               oempty,
  output logic [CNT_W-1:0]   ocount
);

  localparam int PTR_W = f_ptr_w(pDEPTH);

  logic [pDATA_W-1:0] r_mem [pDEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign w_full    = (r_count == CNT_W'(pDEPTH));
  assign oempty    = (r_count == '0);
  assign w_pop_ok  = ipop && !oempty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push_ok = ipush && (!w_full || w_pop_ok);
  assign ocount    = r_count;
  // Hold the output at zero while empty so stale entries never leak out.
  assign odat      = oempty ? '0 : r_mem[r_rd];

  // Storage, pointers and occupancy.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < pDEPTH; i++) r_mem[i] <= '0;
    end else if (isclr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= idat;
        r_wr        <= (r_wr == PTR_W'(pDEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd <= (r_rd == PTR_W'(pDEPTH - 1)) ? '0 : r_rd + 1'b1;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wt_fir_ctrl.sv
// Sequencer for one FIR stage: load strobe, compute window, capture, decimate, buffer.
module wt_fir_ctrl
  import wt_fir_ctrl_pkg::*;
#(
  parameter int pWIDTH = 12,
  parameter int pORDER = 12,
  parameter int pCALC  = pORDER + 2,
  parameter int pDECIM = 2,
  parameter int pDEPTH = 2
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                isclr,
  input  logic                ival,
  input  logic [pWIDTH-1:0]   idat,
  output logic                ordy,
  output logic                ofir_clk_ena,
  output logic                ofir_ena,
  output logic [pWIDTH-1:0]   ofir_dat,
  input  logic [2*pWIDTH-1:0] ifir_dat,
  output logic                oval,
  output logic [2*pWIDTH-1:0] odat,
  input  logic                irdy,
  output logic                obusy
);

  localparam int RES_W = 2 * pWIDTH;
  localparam int CNT_W = f_cnt_w(pCALC);
  localparam int FCNT_W = f_clog2(pDEPTH + 1);
  localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(pCALC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_phase;
  logic              w_phase_nxt;
  logic [pWIDTH-1:0] r_fir_dat;
  logic [pWIDTH-1:0] w_fir_dat_nxt;
  logic              w_load;
  logic              w_push;
  logic              w_pop;
  logic              w_space;
  logic              w_empty;
  logic [FCNT_W-1:0] w_count;

  // Acceptance needs a free slot so the later capture can never overflow.
  assign w_space = (w_count < FCNT_W'(pDEPTH));

  // State, counter, decimation phase and presented sample.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_fir_dat <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_fir_dat <= w_fir_dat_nxt;
    end
  end

  // Next-state and strobe decode; a synchronous clear overrides every state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_fir_dat_nxt = r_fir_dat;
    w_load        = 1'b0;
    w_push        = 1'b0;
    if (isclr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (ival && w_space) begin
            w_fir_dat_nxt = idat;
            w_state_nxt   = LOAD;
          end
        end
        LOAD: begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = CALC;
        end
        CALC: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CALC_LAST) w_state_nxt = CAPT;
        end
        CAPT: begin
          w_push      = (r_phase == 1'b0);
          w_phase_nxt = (pDECIM == 2) ? ~r_phase : 1'b0;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign ordy         = !irst && (r_state == IDLE) && w_space && !isclr;
  assign ofir_clk_ena = w_load;
  assign ofir_ena     = w_load;
  assign ofir_dat     = r_fir_dat;
  assign obusy        = (r_state != IDLE);
  assign oval         = !w_empty;
  assign w_pop        = oval && irdy;

  wt_fir_ctrl_fifo #(
    .pDATA_W (RES_W),
    .pDEPTH  (pDEPTH)
  ) u_fifo (
    .iclk   (iclk),
    .irst   (irst),
    .isclr  (isclr),
    .ipush  (w_push),
    .idat   (ifir_dat),
    .ipop   (w_pop),
    .odat   (odat),
    .oempty (w_empty),
    .ocount (w_count)
  );

endmodule

// File: tb/tb_wt_fir_ctrl.sv
// Scoreboard bench for wt_fir_ctrl with a behavioural 12-tap FIR (taps 2..13).
module tb_wt_fir_ctrl;

  logic        iclk;
  logic        irst;
  logic        isclr;
  logic        ival;
  logic [11:0] idat;
  logic        ordy;
  logic        ofir_clk_ena;
  logic        ofir_ena;
  logic [11:0] ofir_dat;
  logic [23:0] ifir_dat;
  logic        oval;
  logic [23:0] odat;
  logic        irdy;
  logic        obusy;

  int n_total = 0;
  int n_pass  = 0;
  int n_out   = 0;
  logic [23:0] exp_q[$];

  wt_fir_ctrl #(
    .pWIDTH (12),
    .pORDER (12),
    .pCALC  (14),
    .pDECIM (2),
    .pDEPTH (2)
  ) u_dut (
    .iclk         (iclk),
    .irst         (irst),
    .isclr        (isclr),
    .ival         (ival),
    .idat         (idat),
    .ordy         (ordy),
    .ofir_clk_ena (ofir_clk_ena),
    .ofir_ena     (ofir_ena),
    .ofir_dat     (ofir_dat),
    .ifir_dat     (ifir_dat),
    .oval         (oval),
    .odat         (odat),
    .irdy         (irdy),
    .obusy        (obusy)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // FIR model: delay line shifts on the load strobe, result is combinational.
  logic [11:0] r_taps [12];
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int k = 0; k < 12; k++) r_taps[k] <= '0;
    end else if (ofir_clk_ena) begin
      r_taps[0] <= ofir_dat;
      for (int k = 1; k < 12; k++) r_taps[k] <= r_taps[k-1];
    end
  end

  always_comb begin
    ifir_dat = '0;
    for (int k = 0; k < 12; k++) ifir_dat = ifir_dat + 24'(k + 2) * 24'(r_taps[k]);
  end

  // Monitor: every accepted output must match the head of the expectation queue.
  always @(negedge iclk) begin
    logic [23:0] e;
    #2;
    if (oval && irdy) begin
      n_out++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL result_unexpected: got 0x%0h, want none", odat);
      end else begin
        e = exp_q.pop_front();
        if (odat === e) n_pass++;
        else $display("FAIL result_value: got 0x%0h, want 0x%0h", odat, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge iclk);
    #1;
  endtask

  task automatic do_reset();
    irst = 1'b1;
    step();
    irst = 1'b0;
    step();
  endtask

  // Offer a sample and return in the LOAD cycle that follows acceptance.
  task automatic send(input logic [11:0] d);
    int n;
    n = 0;
    ival = 1'b1;
    idat = d;
    while (!ordy && n < 100) begin
      step();
      n++;
    end
    check("send_accept", {31'd0, ordy}, 32'd1);
    step();
    ival = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int out0;
    logic seen_rdy;
    logic bad_dat;
    irst  = 1'b1;
    isclr = 1'b0;
    ival  = 1'b0;
    idat  = '0;
    irdy  = 1'b0;
    step();
    step();
    check("rst_ordy", {31'd0, ordy}, 0);
    check("rst_oval", {31'd0, oval}, 0);
    check("rst_odat", {8'd0, odat}, 0);
    check("rst_fir_clk_ena", {31'd0, ofir_clk_ena}, 0);
    check("rst_fir_ena", {31'd0, ofir_ena}, 0);
    check("rst_fir_dat", {20'd0, ofir_dat}, 0);
    check("rst_obusy", {31'd0, obusy}, 0);
    irst = 1'b0;
    step();

    // Single sample: strobe timing and capture latency.
    irdy = 1'b1;
    exp_q.push_back(24'h000246);
    send(12'h123);
    check("load_strobe", {31'd0, ofir_clk_ena}, 1);
    check("load_ena", {31'd0, ofir_ena}, 1);
    check("load_dat", {20'd0, ofir_dat}, 32'h123);
    check("load_busy", {31'd0, obusy}, 1);
    step();
    check("strobe_one_cycle", {31'd0, ofir_clk_ena}, 0);
    n = 1;
    while (!oval && n < 40) begin
      step();
      n++;
    end
    check("push_latency", n, 16);
    step();
    check("oval_one_cycle", {31'd0, oval}, 0);

    // Decimation by 2 over an impulse.
    do_reset();
    irdy = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) exp_q.push_back(24'h000FFE);
      if (i == 2) exp_q.push_back(24'h001FFC);
      if (i == 4) exp_q.push_back(24'h002FFA);
      send((i == 0) ? 12'h7FF : 12'h000);
    end
    drain();
    repeat (40) step();
    check("decim_count", n_out - out0, 3);

    // Backpressure: FIFO fills, ordy stays low, head held stable.
    do_reset();
    irdy = 1'b0;
    exp_q.push_back(24'h000020);
    send(12'h010);
    send(12'h020);
    exp_q.push_back(24'h000100);
    send(12'h030);
    ival = 1'b1;
    idat = 12'h040;
    seen_rdy = 1'b0;
    bad_dat  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      seen_rdy |= ordy;
      bad_dat  |= (odat !== 24'h000020);
    end
    check("ordy_low_full", {31'd0, seen_rdy}, 0);
    check("odat_stable", {31'd0, bad_dat}, 0);
    check("full_oval", {31'd0, oval}, 1);
    irdy = 1'b1;
    check("ordy_before_pop", {31'd0, ordy}, 0);
    step();
    check("ordy_after_pop", {31'd0, ordy}, 1);
    step();
    ival = 1'b0;
    check("third_accepted", {31'd0, obusy}, 1);
    exp_q.push_back(24'h000320);
    send(12'h050);
    drain();

    // Push and pop in the same cycle at capture.
    do_reset();
    irdy = 1'b0;
    exp_q.push_back(24'h000200);
    send(12'h100);
    send(12'h001);
    exp_q.push_back(24'h000407);
    send(12'h002);
    repeat (15) step();
    check("pp_capt_busy", {31'd0, obusy}, 1);
    check("pp_one_held", {31'd0, oval}, 1);
    irdy = 1'b1;
    step();
    check("pp_oval_kept", {31'd0, oval}, 1);
    step();
    check("pp_drained", {31'd0, oval}, 0);
    check("pp_queue", exp_q.size(), 0);

    // Synchronous clear mid-window resets the decimation phase.
    do_reset();
    irdy = 1'b1;
    exp_q.push_back(24'h000006);
    send(12'h003);
    drain();
    repeat (20) step();
    send(12'h005);
    repeat (6) step();
    isclr = 1'b1;
    check("sclr_ordy", {31'd0, ordy}, 0);
    step();
    check("sclr_idle", {31'd0, obusy}, 0);
    check("sclr_oval", {31'd0, oval}, 0);
    check("sclr_strobe", {31'd0, ofir_clk_ena}, 0);
    check("sclr_fir_dat", {20'd0, ofir_dat}, 32'h005);
    isclr = 1'b0;
    exp_q.push_back(24'h000029);
    send(12'h007);
    drain();

    // Asynchronous reset between edges during capture.
    do_reset();
    irdy = 1'b0;
    send(12'h0AA);
    send(12'h0CC);
    repeat (15) step();
    check("arst_pre_busy", {31'd0, obusy}, 1);
    check("arst_pre_oval", {31'd0, oval}, 1);
    #2;
    irst = 1'b1;
    #1;
    check("arst_busy", {31'd0, obusy}, 0);
    check("arst_oval", {31'd0, oval}, 0);
    check("arst_odat", {8'd0, odat}, 0);
    check("arst_ordy", {31'd0, ordy}, 0);
    check("arst_fir_dat", {20'd0, ofir_dat}, 0);
    step();
    irst = 1'b0;
    irdy = 1'b1;
    step();
    out0 = n_out;
    exp_q.push_back(24'h000176);
    send(12'h0BB);
    drain();
    repeat (30) step();
    check("arst_out_count", n_out - out0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
